// File: rtl/arbiter_rr_pkt_buf_n.sv
// N-to-1 round-robin arbiter with optional packet lock feeding a 2-entry
// registered output buffer; each beat carries the index of its source channel.
module arbiter_rr_pkt_buf_n #(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_PKT = 1,
  parameter int unsigned SRC_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             in_valid,
  input  logic [N-1:0][DWIDTH-1:0] in_data,
  input  logic [N-1:0]             in_last,
  output logic [N-1:0]             in_ready,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_last,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N - 1);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   lock_q, lock_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         count_q, count_d;

  logic [DWIDTH-1:0]  hd_data_q, hd_data_d, tl_data_q, tl_data_d;
  logic               hd_last_q, hd_last_d, tl_last_q, tl_last_d;
  logic [SRC_W-1:0]   hd_src_q, hd_src_d, tl_src_q, tl_src_d;

  logic               gnt_found;
  logic [SRC_W-1:0]   gnt_idx;
  int unsigned        cand;
  logic               can_acc;
  logic               push;
  logic               pop;

  assign can_acc   = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = |(in_ready & in_valid);

  assign out_data  = hd_data_q;
  assign out_last  = hd_last_q;
  assign out_src   = hd_src_q;

  // A locked channel keeps the grant even while its valid is low, so a
  // mid-packet gap stalls the arbiter instead of releasing the lock.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (state_q == ST_LOCKED) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_q;
    end else begin
      for (int unsigned off = 0; off < N; off++) begin
        cand = 32'(ptr_q) + off;
        if (cand >= N) begin
          cand = cand - N;
        end
        if (!gnt_found && in_valid[SRC_W'(cand)]) begin
          gnt_found = 1'b1;
          gnt_idx   = SRC_W'(cand);
        end
      end
    end
  end

  // Held low during reset so nothing handshakes while the state is cleared.
  always_comb begin
    in_ready = '0;
    if (rst && can_acc && gnt_found) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (push) begin
      if ((LOCK_PKT != 0) && !in_last[gnt_idx]) begin
        state_d = ST_LOCKED;
        lock_d  = gnt_idx;
      end else begin
        state_d = ST_OPEN;
        ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SRC_W'(1);
      end
    end
  end

  // Pop shifts the tail forward first; a push then lands in the first free slot.
  always_comb begin
    count_d   = count_q;
    hd_data_d = hd_data_q;
    hd_last_d = hd_last_q;
    hd_src_d  = hd_src_q;
    tl_data_d = tl_data_q;
    tl_last_d = tl_last_q;
    tl_src_d  = tl_src_q;
    if (pop) begin
      hd_data_d = tl_data_q;
      hd_last_d = tl_last_q;
      hd_src_d  = tl_src_q;
      count_d   = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        hd_data_d = in_data[gnt_idx];
        hd_last_d = in_last[gnt_idx];
        hd_src_d  = gnt_idx;
      end else begin
        tl_data_d = in_data[gnt_idx];
        tl_last_d = in_last[gnt_idx];
        tl_src_d  = gnt_idx;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_OPEN;
      lock_q    <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      hd_data_q <= '0;
      hd_last_q <= 1'b0;
      hd_src_q  <= '0;
      tl_data_q <= '0;
      tl_last_q <= 1'b0;
      tl_src_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      hd_data_q <= hd_data_d;
      hd_last_q <= hd_last_d;
      hd_src_q  <= hd_src_d;
      tl_data_q <= tl_data_d;
      tl_last_q <= tl_last_d;
      tl_src_q  <= tl_src_d;
    end
  end

endmodule
